pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline with the floating-point unit.
//  - Drives the IF/ID write enable, IF/ID flush, PC write and ID/EX write/bubble controls.
//  - Detects load-use hazards and squashes on taken branches.
//  - Freezes the front end for the full multi-cycle latency of FP add/mul/div in EX.

---
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 57 +++++
 tb/tb_pipeline_hazard_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it.
// Optional stall_cycles signal exists only with HAZ_PERF_CNT_EN.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic [1:0]  id_fp_op;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rt;
   logic        ex_branch_taken;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_write;
   logic        id_ex_bubble;
   logic        ex_mem_bubble;
   logic        fpu_start;
   logic        fpu_busy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif
   modport master (
      output id_rs, id_rt, id_uses_rt, id_fp_op, id_ex_mem_read, id_ex_rt, ex_branch_taken,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble,
             fpu_start, fpu_busy
`ifdef HAZ_PERF_CNT_EN
      , input stall_cycles
`endif
   );
   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_fp_op, id_ex_mem_read, id_ex_rt, ex_branch_taken,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble,
             fpu_start, fpu_busy
`ifdef HAZ_PERF_CNT_EN
      , output stall_cycles
`endif
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch squash and multi-cycle FP freeze sequencer.
// Define HAZ_PERF_CNT_EN to add the saturating stall_cycles counter.
module pipeline_hazard_ctrl #(
   parameter int FP_ADD_LAT = 3,
   parameter int FP_MUL_LAT = 4,
   parameter int FP_DIV_LAT = 10,
   parameter int CNT_W      = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic {IDLE, FP_BUSY} state_t;
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, lat_m1;
   logic             start_q, load_use, branch, freeze, stall, issue;
   assign load_use = hz.id_ex_mem_read && hz.id_ex_rt != 5'd0 &&
                     (hz.id_ex_rt == hz.id_rs || (hz.id_uses_rt && hz.id_ex_rt == hz.id_rt));
   assign lat_m1 = hz.id_fp_op == 2'b01 ? CNT_W'(FP_ADD_LAT - 1) :
                   hz.id_fp_op == 2'b10 ? CNT_W'(FP_MUL_LAT - 1) : CNT_W'(FP_DIV_LAT - 1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         start_q <= issue;
      end
   end
   // Branches resolve only in IDLE; during FP_BUSY the EX slot belongs to the FP op.
   always_comb begin
      freeze   = state == FP_BUSY && cnt != '0;
      branch   = state == IDLE && hz.ex_branch_taken;
      stall    = !branch && !freeze && load_use;
      issue    = !branch && !freeze && !load_use && hz.id_fp_op != 2'b00;
      state_nx = (issue || freeze) ? FP_BUSY : IDLE;
      cnt_nx   = issue ? lat_m1 : freeze ? cnt - 1'b1 : cnt;
      hz.pc_write      = reset_n && !freeze && !stall;
      hz.if_id_write   = reset_n && !freeze && !stall;
      hz.if_id_flush   = reset_n && branch;
      hz.id_ex_write   = reset_n && !freeze;
      hz.id_ex_bubble  = reset_n && (branch || stall);
      hz.ex_mem_bubble = reset_n && freeze;
      hz.fpu_start     = reset_n && start_q;
      hz.fpu_busy      = reset_n && state == FP_BUSY;
   end
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stall_q <= '0;
      else if (!hz.pc_write && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
   end
   assign hz.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors and FP latency sequences for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
   logic clk, reset_n;
   int   n_run, n_fail;
   pipeline_hazard_ctrl_if hz();
   pipeline_hazard_ctrl dut (.clk(clk), .reset_n(reset_n), .hz(hz));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, fpu_start, fpu_busy}
   logic [7:0] outs;
   assign outs = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
                  hz.id_ex_bubble, hz.ex_mem_bubble, hz.fpu_start, hz.fpu_busy};
   typedef struct {
      string      nm;
      logic [4:0] rs, rt;
      logic       uses, mem;
      logic [4:0] ex_rt;
      logic       br;
      logic [7:0] exp;
   } vec_t;
   vec_t v[9];
   task automatic chk(input string nm, input logic [7:0] exp);
      n_run++;
      if (outs !== exp) begin
         n_fail++;
         $display("FAIL %s: outputs=%b expected=%b", nm, outs, exp);
      end
   endtask
   task automatic step;
      @(negedge clk);
   endtask
   task automatic set_in(input logic [4:0] rs, rt, input logic uses, mem,
                         input logic [4:0] ex_rt, input logic br, input logic [1:0] op);
      hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = uses; hz.id_ex_mem_read = mem;
      hz.id_ex_rt = ex_rt; hz.ex_branch_taken = br; hz.id_fp_op = op;
   endtask
   initial begin
`ifdef HAZ_PERF_CNT_EN
      logic [31:0] s0;
`endif
      n_run = 0; n_fail = 0;
      v[0] = '{"loaduse_rs",   5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 8'b0001_1000};
      v[1] = '{"loaduse_rt",   5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 8'b0001_1000};
      v[2] = '{"r0_no_stall",  5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 8'b1101_0000};
      v[3] = '{"rt_not_used",  5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 8'b1101_0000};
      v[4] = '{"not_a_load",   5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 8'b1101_0000};
      v[5] = '{"branch_lduse", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 8'b1111_1000};
      v[6] = '{"branch_only",  5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 8'b1111_1000};
      v[7] = '{"rs_mismatch",  5'd6, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 8'b1101_0000};
      v[8] = '{"no_match",     5'd4, 5'd8, 1'b1, 1'b1, 5'd9, 1'b0, 8'b1101_0000};
      reset_n = 1'b0;
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
      step; #1 chk("reset_outputs", 8'b0000_0000);
      step; reset_n = 1'b1;
      #1 chk("after_reset", 8'b1101_0000);
`ifdef HAZ_PERF_CNT_EN
      n_run++;
      if (hz.stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL stall_cycles_reset: got=%0d expected=0", hz.stall_cycles);
      end
`endif
      for (int i = 0; i < 9; i++) begin
         step;
         set_in(v[i].rs, v[i].rt, v[i].uses, v[i].mem, v[i].ex_rt, v[i].br, 2'b00);
         #1 chk(v[i].nm, v[i].exp);
      end
      step;
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
      #1 chk("idle_again", 8'b1101_0000);
`ifdef HAZ_PERF_CNT_EN
      s0 = hz.stall_cycles;
`endif
      // FP mul: 3 freeze cycles, branches ignored while frozen
      step; hz.id_fp_op = 2'b10; #1 chk("mul_issue", 8'b1101_0000);
      step; hz.id_fp_op = 2'b00; #1 chk("mul_freeze1", 8'b0000_0111);
      step; hz.ex_branch_taken = 1'b1; #1 chk("mul_freeze2_br", 8'b0000_0101);
      step; #1 chk("mul_freeze3_br", 8'b0000_0101);
      step; hz.ex_branch_taken = 1'b0; #1 chk("mul_release", 8'b1101_0001);
      step; #1 chk("mul_idle", 8'b1101_0000);
`ifdef HAZ_PERF_CNT_EN
      n_run++;
      if (hz.stall_cycles !== s0 + 32'd3) begin
         n_fail++;
         $display("FAIL stall_cycles_mul: got=%0d expected=%0d", hz.stall_cycles, s0 + 32'd3);
      end
`endif
      // FP div then FP add back to back
      step; hz.id_fp_op = 2'b11; #1 chk("div_issue", 8'b1101_0000);
      step; hz.id_fp_op = 2'b00; #1 chk("div_freeze1", 8'b0000_0111);
      for (int i = 2; i <= 9; i++) begin
         step; #1 chk($sformatf("div_freeze%0d", i), 8'b0000_0101);
      end
      step; hz.id_fp_op = 2'b01; #1 chk("div_release_add_issue", 8'b1101_0001);
      step; hz.id_fp_op = 2'b00; #1 chk("add_freeze1", 8'b0000_0111);
      step; #1 chk("add_freeze2", 8'b0000_0101);
      step; #1 chk("add_release", 8'b1101_0001);
      step; #1 chk("add_idle", 8'b1101_0000);
      // load-use on the result cycle blocks a new FP issue
      step; hz.id_fp_op = 2'b01; #1 chk("add2_issue", 8'b1101_0000);
      step; hz.id_fp_op = 2'b00; #1 chk("add2_freeze1", 8'b0000_0111);
      step; #1 chk("add2_freeze2", 8'b0000_0101);
      step; set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 2'b10);
      #1 chk("result_loaduse", 8'b0001_1001);
      step; set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
      #1 chk("no_issue_idle", 8'b1101_0000);
      // reset in second FP_BUSY cycle
      step; hz.id_fp_op = 2'b11; #1 chk("div2_issue", 8'b1101_0000);
      step; hz.id_fp_op = 2'b00; #1 chk("div2_freeze1", 8'b0000_0111);
      step; reset_n = 1'b0; #1 chk("reset_mid_busy", 8'b0000_0000);
      step; reset_n = 1'b1; #1 chk("reset_release", 8'b1101_0000);
`ifdef HAZ_PERF_CNT_EN
      n_run++;
      if (hz.stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL stall_cycles_rst: got=%0d expected=0", hz.stall_cycles);
      end
`endif
      step; #1 chk("op_discarded", 8'b1101_0000);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
